ctrl_cfg_master: RTL

- Control-plane initiator for the unimon_top configuration bus.
- Accepts high-level table commands (connection-entry write, delete or read; hash-table write) on a valid/ready port.
- Serialises each command into single-cycle ctrl_in_valid transactions with the fixed address format and inter-command spacing.
- Collects read returns from ctrl_out_valid/ctrl_data_out and reports one response per command. Ctrl outputs wire directly to unimon_top.

---
 rtl/ctrl_cfg_master.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/ctrl_cfg_master.sv
// Configuration-bus initiator: turns table commands into spaced ctrl_in_valid pulses and collects read data.
// States: IDLE wait for command | ISSUE one bus pulse | WAIT_RD await read data | GAP inter-pulse spacing | RESP report.
module ctrl_cfg_master #(
  parameter int GAP_CYCLES = 10,
  parameter int RD_TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_type,
  input  logic [15:0]  cmd_index,
  input  logic [159:0] cmd_entry,
  input  logic [3:0]   cmd_hash_tb,
  input  logic [31:0]  cmd_hash_data,
  output logic         ctrl_in_valid,
  output logic [1:0]   ctrl_opt,
  output logic [31:0]  ctrl_addr,
  output logic [31:0]  ctrl_data_in,
  input  logic         ctrl_out_valid,
  input  logic [31:0]  ctrl_data_out,
  output logic         rsp_valid,
  output logic [1:0]   rsp_status,
  output logic [159:0] rsp_data
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int TW = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [TW-1:0] TMO_LOAD = TW'((RD_TIMEOUT > 0) ? RD_TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_RD,
    S_GAP,
    S_RESP
  } state_t;

  state_t         state_q, state_d;
  logic           ready_q;
  logic [2:0]     word_q, word_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic [1:0]     type_q, type_d;
  logic [15:0]    index_q, index_d;
  logic [159:0]   entry_q, entry_d;
  logic [3:0]     hash_tb_q, hash_tb_d;
  logic [31:0]    hash_data_q, hash_data_d;
  logic [1:0]     status_q, status_d;
  logic [159:0]   rdata_q, rdata_d;
  logic           end_txn, gap_done, advance, abort, more;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b0;
      word_q      <= '0;
      gap_q       <= '0;
      tmo_q       <= '0;
      type_q      <= '0;
      index_q     <= '0;
      entry_q     <= '0;
      hash_tb_q   <= '0;
      hash_data_q <= '0;
      status_q    <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= (state_d == S_IDLE);
      word_q      <= word_d;
      gap_q       <= gap_d;
      tmo_q       <= tmo_d;
      type_q      <= type_d;
      index_q     <= index_d;
      entry_q     <= entry_d;
      hash_tb_q   <= hash_tb_d;
      hash_data_q <= hash_data_d;
      status_q    <= status_d;
      rdata_q     <= rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    gap_d       = gap_q;
    tmo_d       = tmo_q;
    type_d      = type_q;
    index_d     = index_q;
    entry_d     = entry_q;
    hash_tb_d   = hash_tb_q;
    hash_data_d = hash_data_q;
    status_d    = status_q;
    rdata_d     = rdata_q;
    end_txn     = 1'b0;
    gap_done    = 1'b0;
    advance     = 1'b0;
    abort       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && ready_q) begin
          type_d      = cmd_type;
          index_d     = cmd_index;
          entry_d     = cmd_entry;
          hash_tb_d   = cmd_hash_tb;
          hash_data_d = cmd_hash_data;
          rdata_d     = '0;
          status_d    = 2'd0;
          word_d      = '0;
          gap_d       = '0;
          tmo_d       = '0;
          if (cmd_type == 2'd2 && cmd_hash_tb != 4'd1 && cmd_hash_tb != 4'd2) begin
            state_d  = S_RESP;
            status_d = 2'd2;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (type_q == 2'd3) begin
          state_d = S_WAIT_RD;
          tmo_d   = TMO_LOAD;
        end else begin
          end_txn = 1'b1;
        end
      end
      S_WAIT_RD: begin
        if (ctrl_out_valid) begin
          rdata_d[32*word_q +: 32] = ctrl_data_out;
          end_txn = 1'b1;
        end else if (tmo_q == '0) begin
          status_d = 2'd1;
          abort    = 1'b1;
          end_txn  = 1'b1;
        end else begin
          tmo_d = tmo_q - 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q == '0) gap_done = 1'b1;
        else             gap_d = gap_q - 1'b1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A timeout (this cycle or recorded earlier) ends the word sequence.
    more = (type_q == 2'd0 || type_q == 2'd3) && (word_q != 3'd4) && !abort && (status_q != 2'd1);

    if (end_txn) begin
      if (GAP_CYCLES == 0) begin
        advance = 1'b1;
      end else begin
        state_d = S_GAP;
        gap_d   = GAP_LOAD;
      end
    end
    if (gap_done) advance = 1'b1;
    if (advance) begin
      if (more) begin
        state_d = S_ISSUE;
        word_d  = word_q + 1'b1;
      end else begin
        state_d = S_RESP;
      end
    end
  end

  always_comb begin
    ctrl_opt     = 2'd0;
    ctrl_addr    = 32'd0;
    ctrl_data_in = 32'd0;
    if (state_q == S_ISSUE) begin
      ctrl_addr = {8'd0, (type_q == 2'd2) ? hash_tb_q : 4'd0, index_q, 1'b0, word_q};
      case (type_q)
        2'd0: begin
          ctrl_opt     = 2'd1;
          ctrl_data_in = entry_q[32*word_q +: 32];
        end
        2'd1: ctrl_opt = 2'd0;
        2'd2: begin
          ctrl_opt     = 2'd1;
          ctrl_data_in = hash_data_q;
        end
        default: ctrl_opt = 2'd3;
      endcase
    end
  end

  assign cmd_ready     = ready_q;
  assign ctrl_in_valid = (state_q == S_ISSUE);
  assign rsp_valid     = (state_q == S_RESP);
  assign rsp_status    = status_q;
  assign rsp_data      = rdata_q;

endmodule
